// File: rtl/motor_plant_model.sv
// motor_plant_model
//   Synthesizable model of a motorised actuator, used to close the loop around a
//   motor controller. It integrates the controller's up/down drive into a travel
//   position, reports the end-of-travel limit switches, and latches a fault on
//   illegal drive: both directions at once, or pushing against a limit for too long.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   motor_up     in   drive toward TRAVEL
//   motor_dn     in   drive toward 0
//   clear_fault  in   request exit from FAULT (honoured only with both drives low)
//   up_limit     out  position == TRAVEL
//   dn_limit     out  position == 0
//   position     out  current position, registered
//   moving       out  position is advancing in the current direction
//   fault        out  plant is in FAULT
//   fault_code   out  00 none, 01 both drives high, 10 limit overrun
module motor_plant_model #(
  parameter int POS_W          = 8,
  parameter int TRAVEL         = 100,
  parameter int STEP_DIV       = 4,
  parameter int INIT_POS       = 0,
  parameter int OVERRUN_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             motor_up,
  input  logic             motor_dn,
  input  logic             clear_fault,
  output logic             up_limit,
  output logic             dn_limit,
  output logic [POS_W-1:0] position,
  output logic             moving,
  output logic             fault,
  output logic [1:0]       fault_code
);

  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int CW = $clog2(OVERRUN_CYCLES + 1);

  localparam logic [POS_W-1:0] POS_TOP  = POS_W'(TRAVEL);
  localparam logic [POS_W-1:0] POS_INIT = POS_W'(INIT_POS);
  localparam logic [PW-1:0]    PRE_LAST = PW'(STEP_DIV - 1);
  localparam logic [CW-1:0]    OVR_MAX  = CW'(OVERRUN_CYCLES);

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_BOTH    = 2'b01;
  localparam logic [1:0] CODE_OVERRUN = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_UP,
    S_DN,
    S_FAULT
  } state_t;

  state_t           state, state_nx;
  logic [PW-1:0]    presc, presc_nx;
  logic [CW-1:0]    ovr, ovr_nx;
  logic [POS_W-1:0] pos_nx;
  logic [1:0]       code_nx;
  logic             push;

  // Push-against-limit detection is independent of state; the count saturates
  // so it cannot wrap back below the fault threshold.
  assign push = (motor_up && (position == POS_TOP)) ||
                (motor_dn && (position == '0));

  always_comb begin
    state_nx = state;
    presc_nx = presc;
    pos_nx   = position;
    code_nx  = fault_code;
    ovr_nx   = '0;

    if (push) begin
      ovr_nx = (ovr == OVR_MAX) ? ovr : ovr + 1'b1;
    end

    case (state)
      S_FAULT: begin
        // Position and prescaler stay frozen; only a clean clear leaves FAULT.
        if (clear_fault && !motor_up && !motor_dn) begin
          state_nx = S_IDLE;
          code_nx  = CODE_NONE;
          ovr_nx   = '0;
        end
      end

      default: begin
        if (motor_up && motor_dn) begin
          state_nx = S_FAULT;
          code_nx  = CODE_BOTH;
        end else if (ovr_nx == OVR_MAX) begin
          state_nx = S_FAULT;
          code_nx  = CODE_OVERRUN;
        end else begin
          if (motor_up) begin
            state_nx = S_UP;
          end else if (motor_dn) begin
            state_nx = S_DN;
          end else begin
            state_nx = S_IDLE;
          end

          // A step is only taken while staying in the same direction; any new
          // direction restarts the prescaler so the first step is a full period away.
          if (state_nx != state) begin
            if (state_nx != S_IDLE) begin
              presc_nx = '0;
            end
          end else if ((state == S_UP) && (position != POS_TOP)) begin
            if (presc == PRE_LAST) begin
              presc_nx = '0;
              pos_nx   = position + 1'b1;
            end else begin
              presc_nx = presc + 1'b1;
            end
          end else if ((state == S_DN) && (position != '0)) begin
            if (presc == PRE_LAST) begin
              presc_nx = '0;
              pos_nx   = position - 1'b1;
            end else begin
              presc_nx = presc + 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      position   <= POS_INIT;
      presc      <= '0;
      ovr        <= '0;
      fault_code <= CODE_NONE;
    end else begin
      state      <= state_nx;
      position   <= pos_nx;
      presc      <= presc_nx;
      ovr        <= ovr_nx;
      fault_code <= code_nx;
    end
  end

  assign up_limit = (position == POS_TOP);
  assign dn_limit = (position == '0);
  assign fault    = (state == S_FAULT);
  assign moving   = ((state == S_UP) && (position != POS_TOP)) ||
                    ((state == S_DN) && (position != '0));

endmodule

// File: tb/tb_motor_plant_model.sv
// tb_motor_plant_model
//   Directed scenarios plus a randomized run checked against a behavioural model
//   of the actuator (direction, step timer, push streak, fault latch).
module tb_motor_plant_model;

  localparam int POS_W    = 8;
  localparam int TRAVEL   = 100;
  localparam int STEP_DIV = 4;
  localparam int INIT_POS = 0;
  localparam int OVR      = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             motor_up;
  logic             motor_dn;
  logic             clear_fault;
  logic             up_limit;
  logic             dn_limit;
  logic [POS_W-1:0] position;
  logic             moving;
  logic             fault;
  logic [1:0]       fault_code;

  int tests = 0;
  int fails = 0;

  motor_plant_model #(
    .POS_W(POS_W), .TRAVEL(TRAVEL), .STEP_DIV(STEP_DIV),
    .INIT_POS(INIT_POS), .OVERRUN_CYCLES(OVR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .motor_up(motor_up), .motor_dn(motor_dn),
    .clear_fault(clear_fault), .up_limit(up_limit), .dn_limit(dn_limit),
    .position(position), .moving(moving), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  // Behavioural model: dir is -1/0/+1, ticks counts moving cycles since the
  // last step or direction change, run is the consecutive push streak.
  int m_pos, m_dir, m_fault, m_code, m_run, m_ticks;

  task automatic model_edge();
    int want;
    bit at_lim;
    if (!rst_n) begin
      m_pos = INIT_POS; m_dir = 0; m_fault = 0; m_code = 0; m_run = 0; m_ticks = 0;
      return;
    end
    at_lim = (motor_up && m_pos == TRAVEL) || (motor_dn && m_pos == 0);
    m_run  = at_lim ? ((m_run + 1 > OVR) ? OVR : m_run + 1) : 0;
    if (m_fault != 0) begin
      if (clear_fault && !motor_up && !motor_dn) begin
        m_fault = 0; m_code = 0; m_run = 0; m_dir = 0;
      end
      return;
    end
    if (motor_up && motor_dn) begin
      m_fault = 1; m_code = 1; return;
    end
    if (m_run == OVR) begin
      m_fault = 1; m_code = 2; return;
    end
    want = motor_up ? 1 : (motor_dn ? -1 : 0);
    if (want != m_dir) begin
      m_dir = want; m_ticks = 0; return;
    end
    if ((m_dir > 0 && m_pos < TRAVEL) || (m_dir < 0 && m_pos > 0)) begin
      m_ticks++;
      if (m_ticks == STEP_DIV) begin
        m_ticks = 0;
        m_pos  += m_dir;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_in(input logic up, input logic dn, input logic clr);
    motor_up = up; motor_dn = dn; clear_fault = clr;
  endtask

  // Advance until position equals target; reports whether it got there in budget.
  task automatic run_to(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (int'(position) == target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (int'(position) == target) ok = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; set_in(0, 0, 0);
    tick(); tick();
    tests++; if (position !== 8'(INIT_POS)) begin fails++; $display("FAIL reset_pos got %0d want %0d", position, INIT_POS); end
    tests++; if (dn_limit !== 1'b1) begin fails++; $display("FAIL reset_dn_limit got %b want 1", dn_limit); end
    tests++; if (up_limit !== 1'b0) begin fails++; $display("FAIL reset_up_limit got %b want 0", up_limit); end
    tests++; if ({fault, moving, fault_code} !== 4'b0000) begin fails++; $display("FAIL reset_flags got fault=%b moving=%b code=%b want 0/0/00", fault, moving, fault_code); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_travel();
    set_in(1, 0, 0);
    tick();                               // entry edge k
    tests++; if (moving !== 1'b1) begin fails++; $display("FAIL travel_moving got %b want 1", moving); end
    tick(); tick(); tick();               // k+3
    tests++; if (position !== 8'd0) begin fails++; $display("FAIL first_step_early got %0d want 0", position); end
    tick();                               // k+4
    tests++; if (position !== 8'd1) begin fails++; $display("FAIL first_step got %0d want 1", position); end
    for (int i = 0; i < 395; i++) tick(); // k+399
    tests++; if (position !== 8'd99 || up_limit !== 1'b0) begin fails++; $display("FAIL travel_k399 got pos=%0d up_limit=%b want 99/0", position, up_limit); end
    tick();                               // k+400
    tests++; if (position !== 8'd100 || up_limit !== 1'b1) begin fails++; $display("FAIL travel_k400 got pos=%0d up_limit=%b want 100/1", position, up_limit); end
    set_in(0, 0, 0);
    tick();
    tests++; if (fault !== 1'b0 || moving !== 1'b0 || position !== 8'd100) begin fails++; $display("FAIL travel_stop got fault=%b moving=%b pos=%0d want 0/0/100", fault, moving, position); end
  endtask

  task automatic test_overrun();
    set_in(1, 0, 0);
    tick(); tick(); tick();
    tests++; if (fault !== 1'b0) begin fails++; $display("FAIL overrun_early got fault=%b want 0", fault); end
    tick();
    tests++; if (fault !== 1'b1 || fault_code !== 2'b10 || position !== 8'd100) begin fails++; $display("FAIL overrun_fault got fault=%b code=%b pos=%0d want 1/10/100", fault, fault_code, position); end
    set_in(1, 0, 1);
    tick();
    tests++; if (fault !== 1'b1 || fault_code !== 2'b10) begin fails++; $display("FAIL clear_with_drive got fault=%b code=%b want 1/10", fault, fault_code); end
    set_in(0, 0, 1);
    tick();
    tests++; if (fault !== 1'b0 || fault_code !== 2'b00) begin fails++; $display("FAIL clear_fault got fault=%b code=%b want 0/00", fault, fault_code); end
    set_in(0, 0, 0);
    tick();
  endtask

  task automatic test_both_drives();
    bit ok;
    set_in(0, 1, 0);
    run_to(50, 400, ok);
    tests++; if (!ok) begin fails++; $display("FAIL reach_50 got %0d want 50", position); end
    set_in(1, 1, 0);
    tick();
    tests++; if (fault !== 1'b1 || fault_code !== 2'b01 || position !== 8'd50 || moving !== 1'b0) begin fails++; $display("FAIL both_fault got fault=%b code=%b pos=%0d moving=%b want 1/01/50/0", fault, fault_code, position, moving); end
    set_in(0, 0, 1); tick();
    set_in(0, 1, 0);
    run_to(0, 400, ok);
    tests++; if (!ok || dn_limit !== 1'b1) begin fails++; $display("FAIL reach_0 got pos=%0d dn_limit=%b want 0/1", position, dn_limit); end
    set_in(0, 0, 0); tick();
    set_in(1, 1, 0); tick();
    set_in(0, 1, 0);
    for (int i = 0; i < 6; i++) tick();
    tests++; if (fault !== 1'b1 || fault_code !== 2'b01) begin fails++; $display("FAIL first_cause_kept got fault=%b code=%b want 1/01", fault, fault_code); end
    set_in(0, 0, 1); tick();
    set_in(0, 0, 0); tick();
  endtask

  task automatic test_reversal();
    bit ok;
    set_in(1, 0, 0);
    run_to(32, 400, ok);
    set_in(0, 1, 0);
    run_to(30, 100, ok);
    tests++; if (!ok) begin fails++; $display("FAIL reach_30 got %0d want 30", position); end
    set_in(1, 0, 0);
    tick(); tick(); tick(); tick();
    tests++; if (position !== 8'd30) begin fails++; $display("FAIL reversal_early got %0d want 30", position); end
    tick();
    tests++; if (position !== 8'd31) begin fails++; $display("FAIL reversal_step got %0d want 31", position); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    set_in(1, 0, 0);
    run_to(70, 400, ok);
    rst_n = 1'b0;
    tick();
    tests++; if (position !== 8'(INIT_POS) || moving !== 1'b0 || fault !== 1'b0) begin fails++; $display("FAIL reset_mid got pos=%0d moving=%b fault=%b want %0d/0/0", position, moving, fault, INIT_POS); end
    rst_n = 1'b1; set_in(1, 1, 0);
    tick();
    rst_n = 1'b0; set_in(0, 0, 0);
    tick();
    tests++; if (fault !== 1'b0 || fault_code !== 2'b00) begin fails++; $display("FAIL reset_in_fault got fault=%b code=%b want 0/00", fault, fault_code); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    bit e_up, e_dn, e_mv, e_f;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 24) == 0) motor_up = ~motor_up;
      if ($urandom_range(0, 24) == 0) motor_dn = ~motor_dn;
      if (motor_up && motor_dn && $urandom_range(0, 3) != 0) motor_dn = 1'b0;
      clear_fault = ($urandom_range(0, 9) == 0);
      rst_n       = ($urandom_range(0, 799) != 0);
      tick();
      e_up = (m_pos == TRAVEL);
      e_dn = (m_pos == 0);
      e_f  = (m_fault != 0);
      e_mv = !e_f && ((m_dir > 0 && m_pos != TRAVEL) || (m_dir < 0 && m_pos != 0));
      tests++;
      if (position !== 8'(m_pos) || up_limit !== e_up || dn_limit !== e_dn ||
          moving !== e_mv || fault !== e_f || fault_code !== 2'(m_code)) begin
        fails++;
        $display("FAIL random_cycle%0d got pos=%0d up=%b dn=%b mv=%b f=%b code=%b want pos=%0d up=%b dn=%b mv=%b f=%b code=%0d",
                 n, position, up_limit, dn_limit, moving, fault, fault_code,
                 m_pos, e_up, e_dn, e_mv, e_f, m_code);
      end
    end
    rst_n = 1'b1;
    set_in(0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 0);
    test_reset();
    test_full_travel();
    test_overrun();
    test_both_drives();
    test_reversal();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
